// File: rtl/coin_pair_sched_if.sv
// Coin pair scheduler bus: requester side, acceptor side and result handshake.
// master = scheduler, slave = surrounding environment (requesters, acceptor, consumer).
interface coin_pair_sched_if;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  adata;
    logic [7:0]  bdata;
    logic        a_en;
    logic        b_en;
    logic        y_rdy;
    logic [7:0]  ydata;
    logic        y_en;
    logic [7:0]  res_data;
    logic [3:0]  res_tag;
    logic        res_valid;
    logic        res_ready;
    logic        err;

    modport master (
        input  req_data, req_valid, ydata, y_en, res_ready,
        output req_ready, adata, bdata, a_en, b_en, y_rdy,
               res_data, res_tag, res_valid, err
    );

    modport slave (
        output req_data, req_valid, ydata, y_en, res_ready,
        input  req_ready, adata, bdata, a_en, b_en, y_rdy,
               res_data, res_tag, res_valid, err
    );
endinterface

// File: rtl/coin_pair_sched.sv
// Coin pair scheduler: takes two coins from four requesters (round robin),
// hands them to an acceptor, and returns the acceptor result with a tag.
// Optional WAIT timeout compiled in with macro COIN_SCHED_TIMEOUT_EN.
module coin_pair_sched #(
    parameter int unsigned TIMEOUT_CYC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    coin_pair_sched_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE, GRAB_A, GRAB_B, ISSUE, WAIT, RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_a;
    logic [1:0]  r_a_idx;
    logic [1:0]  r_b_idx;
    logic [1:0]  r_rr_ptr;
    logic [7:0]  r_adata;
    logic [7:0]  r_bdata;
    logic [7:0]  r_res_data;
    logic [3:0]  r_res_tag;
    logic        r_res_valid;

    logic        w_a_found;
    logic [1:0]  w_a_idx;
    logic        w_b_found;
    logic [1:0]  w_b_idx;
    logic [3:0]  w_req_ready;
    logic        w_take_a;
    logic        w_take_b;
    logic        w_issue;
    logic        w_capture;
    logic        w_timeout;
    logic        w_release;
    logic        w_tmo_hit;

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("coin_pair_sched: TIMEOUT_CYC must be within 2..255");
    end

    // Round-robin search for the A coin (from rr_ptr) and the B coin (after a_idx).
    always_comb begin
        w_a_found = 1'b0;
        w_a_idx   = '0;
        w_b_found = 1'b0;
        w_b_idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!w_a_found && bus.req_valid[r_rr_ptr + 2'(i)]) begin
                w_a_found = 1'b1;
                w_a_idx   = r_rr_ptr + 2'(i);
            end
        end
        for (int unsigned i = 1; i < 4; i++) begin
            if (!w_b_found && bus.req_valid[r_a_idx + 2'(i)]) begin
                w_b_found = 1'b1;
                w_b_idx   = r_a_idx + 2'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // FSM next-state and strobes.
    always_comb begin
        w_next      = r_state;
        w_req_ready = '0;
        w_take_a    = 1'b0;
        w_take_b    = 1'b0;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|bus.req_valid) w_next = GRAB_A;
            end
            GRAB_A: begin
                if (w_a_found) begin
                    w_req_ready[w_a_idx] = 1'b1;
                    w_take_a             = 1'b1;
                    w_next               = GRAB_B;
                end else begin
                    w_next = IDLE;
                end
            end
            GRAB_B: begin
                if (w_b_found) begin
                    w_req_ready[w_b_idx] = 1'b1;
                    w_take_b             = 1'b1;
                    w_next               = ISSUE;
                end
            end
            ISSUE: begin
                w_issue = 1'b1;
                w_next  = WAIT;
            end
            WAIT: begin
                if (bus.y_en) begin
                    w_capture = 1'b1;
                    w_next    = RESP;
                end else if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                    w_next    = RESP;
                end
            end
            RESP: begin
                if (r_res_valid && bus.res_ready) begin
                    w_release = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Coin latches, operand registers, round-robin pointer and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_a_idx     <= '0;
            r_b_idx     <= '0;
            r_rr_ptr    <= '0;
            r_adata     <= '0;
            r_bdata     <= '0;
            r_res_data  <= '0;
            r_res_tag   <= '0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_take_a) begin
                r_a     <= bus.req_data[{w_a_idx, 3'b000} +: 8];
                r_a_idx <= w_a_idx;
            end
            // Operands are loaded only on the B grant so they stay put outside ISSUE.
            if (w_take_b) begin
                r_adata  <= r_a;
                r_bdata  <= bus.req_data[{w_b_idx, 3'b000} +: 8];
                r_b_idx  <= w_b_idx;
                r_rr_ptr <= w_b_idx + 2'd1;
            end
            if (w_capture) begin
                r_res_data  <= bus.ydata;
                r_res_tag   <= {r_a_idx, r_b_idx};
                r_res_valid <= 1'b1;
            end else if (w_timeout) begin
                r_res_data  <= 8'hFF;
                r_res_tag   <= {r_a_idx, r_b_idx};
                r_res_valid <= 1'b1;
            end else if (w_release) begin
                r_res_valid <= 1'b0;
            end
        end
    end

`ifdef COIN_SCHED_TIMEOUT_EN
    localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] r_tmo_cnt;
    logic       r_err;

    // Fires on the TIMEOUT_CYC-th WAIT cycle without a result.
    assign w_tmo_hit = (r_tmo_cnt == LP_TMO_LAST);

    // WAIT timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_issue)
                r_tmo_cnt <= '0;
            else if (r_state == WAIT && !bus.y_en && !w_tmo_hit)
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign w_tmo_hit = 1'b0;
    assign bus.err   = 1'b0;
`endif

    assign bus.req_ready = w_req_ready;
    assign bus.adata     = r_adata;
    assign bus.bdata     = r_bdata;
    assign bus.a_en      = w_issue;
    assign bus.b_en      = w_issue;
    assign bus.y_rdy     = w_issue;
    assign bus.res_data  = r_res_data;
    assign bus.res_tag   = r_res_tag;
    assign bus.res_valid = r_res_valid;

endmodule

// File: tb/tb_coin_pair_sched.sv
// Directed bench for coin_pair_sched; acceptor modelled as a 1-cycle XOR unit.
module tb_coin_pair_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic stub  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    coin_pair_sched_if bus();

    coin_pair_sched #(.TIMEOUT_CYC(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Acceptor: result = adata ^ bdata one cycle after the strobe; stub suppresses it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.y_en  <= 1'b0;
            bus.ydata <= 8'h00;
        end else begin
            bus.y_en  <= bus.a_en & ~stub;
            bus.ydata <= bus.adata ^ bus.bdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
        chk({tag, "_adata"},     32'(bus.adata),     32'h0);
        chk({tag, "_bdata"},     32'(bus.bdata),     32'h0);
        chk({tag, "_strobes"},   32'({bus.a_en, bus.b_en, bus.y_rdy}), 32'h0);
        chk({tag, "_res_data"},  32'(bus.res_data),  32'h0);
        chk({tag, "_res_tag"},   32'(bus.res_tag),   32'h0);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'h0);
        chk({tag, "_err"},       32'(bus.err),       32'h0);
    endtask

    task automatic wait_res(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            step();
            ok = bus.res_valid;
        end
        chk({tag, "_res_arrived"}, 32'(ok), 32'h1);
    endtask

    initial begin
        logic [3:0] exp_tag [3];
        logic [7:0] exp_dat [3];
        int         bad;
        int         multi;

        exp_tag = '{4'b0001, 4'b1011, 4'b0001};
        exp_dat = '{8'h33, 8'h77, 8'h33};

        bus.req_data  = '0;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;

        // Reset values
        step(); step();
        check_reset("rst");
        rst_n = 1'b1;
        step();

        // Basic pair: lanes 0/1, 5A ^ 0F = 55
        bus.req_data  = 32'h0000_0F5A;
        bus.req_valid = 4'b0011;
        step(); chk("t1_grant_a", 32'(bus.req_ready), 32'b0001);
        step(); chk("t1_grant_b", 32'(bus.req_ready), 32'b0010);
        step();
        chk("t1_issue_strobes", 32'({bus.a_en, bus.b_en, bus.y_rdy}), 32'b111);
        chk("t1_adata", 32'(bus.adata), 32'h5A);
        chk("t1_bdata", 32'(bus.bdata), 32'h0F);
        chk("t1_issue_no_ready", 32'(bus.req_ready), 32'h0);
        bus.req_valid = 4'b0000;
        step();
        chk("t1_strobes_one_cycle", 32'({bus.a_en, bus.b_en, bus.y_rdy}), 32'b000);
        chk("t1_res_not_yet", 32'(bus.res_valid), 32'h0);
        step();
        chk("t1_res_valid", 32'(bus.res_valid), 32'h1);
        chk("t1_res_data",  32'(bus.res_data),  32'h55);
        chk("t1_res_tag",   32'(bus.res_tag),   32'b0001);
        step();
        chk("t1_res_cleared", 32'(bus.res_valid), 32'h0);

        // Round robin with all four requesters valid
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        bus.req_data  = 32'h4433_2211;
        bus.req_valid = 4'b1111;
        multi = 0;
        for (int p = 0; p < 3; p++) begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 30 && !ok; i++) begin
                step();
                if ($countones(bus.req_ready) > 1) multi++;
                ok = bus.res_valid;
            end
            chk($sformatf("t2_res_arrived_%0d", p), 32'(ok), 32'h1);
            chk($sformatf("t2_tag_%0d", p),  32'(bus.res_tag),  32'(exp_tag[p]));
            chk($sformatf("t2_data_%0d", p), 32'(bus.res_data), 32'(exp_dat[p]));
            step();
        end
        bus.req_valid = 4'b0000;
        chk("t2_onehot_ready", 32'(multi), 32'h0);

        // Lone requester 2 holds A in GRAB_B until requester 0 appears
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        bus.req_data  = 32'h0081_0018;
        bus.req_valid = 4'b0100;
        bus.res_ready = 1'b0;
        step(); chk("t3_grant_a2", 32'(bus.req_ready), 32'b0100);
        step();
        bus.req_valid = 4'b0000;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.req_ready !== 4'b0000 || bus.a_en !== 1'b0) bad++;
        end
        chk("t3_hold_grab_b", 32'(bad), 32'h0);
        bus.req_valid = 4'b0001;
        #1 chk("t3_grant_b0", 32'(bus.req_ready), 32'b0001);
        step();
        chk("t3_adata", 32'(bus.adata), 32'h81);
        chk("t3_bdata", 32'(bus.bdata), 32'h18);
        bus.req_valid = 4'b0000;
        wait_res("t3");
        chk("t3_tag",  32'(bus.res_tag),  32'b1000);
        chk("t3_data", 32'(bus.res_data), 32'h99);

        // Backpressure in RESP: result stable, no grants
        bus.req_valid = 4'b1111;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h99 ||
                bus.res_tag !== 4'b1000 || bus.req_ready !== 4'b0000) bad++;
        end
        chk("t4_resp_stable", 32'(bad), 32'h0);
        bus.res_ready = 1'b1;
        step();
        chk("t4_res_cleared", 32'(bus.res_valid), 32'h0);
        chk("t4_idle_no_grant", 32'(bus.req_ready), 32'h0);
        step();
        chk("t4_rr_after_b0", 32'(bus.req_ready), 32'b0010);
        step();
        bus.req_valid = 4'b0000;

        // Reset while holding A in GRAB_B
        #3 rst_n = 1'b0;
        #1 check_reset("t5_rst_grab_b");
        step(); rst_n = 1'b1;
        bus.req_data  = 32'h0000_6633;
        bus.req_valid = 4'b0011;
        stub = 1'b1;
        step(); chk("t5_restart_at_0", 32'(bus.req_ready), 32'b0001);
        step();
        step(); chk("t5_issue", 32'(bus.a_en), 32'h1);
        step(); step(); step();
        chk("t5_wait_no_res", 32'(bus.res_valid), 32'h0);

        // Reset while in WAIT
        #3 rst_n = 1'b0;
        #1 check_reset("t5_rst_wait");
        step(); rst_n = 1'b1;
        step(); chk("t5_wait_restart_at_0", 32'(bus.req_ready), 32'b0001);
        step();
        step(); chk("t6_issue", 32'(bus.a_en), 32'h1);
        bus.req_valid = 4'b0000;

        // Acceptor silent: timeout after TIMEOUT_CYC WAIT cycles, or wait forever
        for (int i = 0; i < 8; i++) step();
        chk("t6_no_res_before_timeout", 32'(bus.res_valid), 32'h0);
        step();
`ifdef COIN_SCHED_TIMEOUT_EN
        chk("t6_timeout_valid", 32'(bus.res_valid), 32'h1);
        chk("t6_timeout_data",  32'(bus.res_data),  32'hFF);
        chk("t6_timeout_tag",   32'(bus.res_tag),   32'b0001);
        chk("t6_timeout_err",   32'(bus.err),       32'h1);
        step(); step();
        chk("t6_released", 32'(bus.res_valid), 32'h0);
        chk("t6_err_sticky", 32'(bus.err), 32'h1);
`else
        chk("t6_still_waiting", 32'(bus.res_valid), 32'h0);
        chk("t6_err_tied_low",  32'(bus.err),       32'h0);
        for (int i = 0; i < 20; i++) step();
        chk("t6_wait_persists", 32'(bus.res_valid), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coin_pair_sched.md
COIN_PAIR_SCHED -- requirements
Module: coin_pair_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 8: cycles allowed in WAIT for acceptor result; legal range 2..255.
REQ-002 The block SHALL use clk as its clock and rst_n as its reset; rst_n is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_data  input  32  requester i payload in bits [8i+7:8i], i=0..3.
REQ-006 req_valid  input  4  requester i holds a coin.
REQ-007 req_ready  output  4  one-hot pulse; requester i's coin consumed this cycle.
REQ-008 adata, bdata  output  8 each  operands driven to acceptor.
REQ-009 a_en, b_en, y_rdy  output  1 each  acceptor strobes.
REQ-010 ydata  input  8  acceptor result.
REQ-011 y_en  input  1  acceptor result valid.
REQ-012 res_data  output  8  result to consumer.
REQ-013 res_tag  output  4  {a_idx[1:0], b_idx[1:0]} requesters that formed the pair.
REQ-014 res_valid  output  1; res_ready  input  1  result handshake.
REQ-015 err  output  1  sticky timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, GRAB_A, GRAB_B, ISSUE, WAIT, RESP.
REQ-017 IDLE -> GRAB_A when any req_valid is high.
REQ-018 GRAB_A: grant lowest index at or after rr_ptr (mod 4) with req_valid high; pulse req_ready for one cycle, latch data into A register, record a_idx, go GRAB_B; if req_valid drops to 0, return to IDLE.
REQ-019 GRAB_B: grant first valid requester searching from a_idx+1 (mod 4), excluding a_idx; pulse req_ready, latch into B, record b_idx, go ISSUE; with no eligible requester, hold A indefinitely.
REQ-020 rr_ptr SHALL load b_idx+1 (mod 4) on each B grant; reset value 0.
REQ-021 ISSUE: assert a_en=b_en=y_rdy=1 for exactly one cycle with adata/bdata from A/B registers; go WAIT.
REQ-022 a_en, b_en, y_rdy SHALL be 0 in every other state; adata/bdata hold last values.
REQ-023 WAIT: on y_en=1 capture ydata into res_data, set res_valid, go RESP; y_en outside WAIT is ignored.
REQ-024 Nominal ISSUE-to-res_valid latency SHALL be 2 cycles (acceptor 1 cycle + capture).
REQ-025 RESP: hold res_data/res_tag/res_valid stable until res_valid && res_ready, then clear res_valid and go IDLE (never directly to GRAB_A).
REQ-026 At most one req_ready bit SHALL be high per cycle; never in ISSUE, WAIT, RESP.
REQ-027 err SHALL set only via REQ-031 and clear only on reset.

Reset
REQ-028 Asserting rst_n low in any state SHALL force IDLE immediately; a latched A coin is discarded.
REQ-029 Reset values: req_ready=0, adata=bdata=0, a_en=b_en=y_rdy=0, res_data=0, res_tag=0, res_valid=0, err=0, rr_ptr=0, timeout counter=0.

Configuration
REQ-030 Macro COIN_SCHED_TIMEOUT_EN SHALL compile in the WAIT timeout logic.
REQ-031 Defined: counter clears on WAIT entry, increments each WAIT cycle without y_en; on reaching TIMEOUT_CYC, set err, res_data=8'hFF, res_valid=1, go RESP.
REQ-032 Undefined: no counter; WAIT persists until y_en; err tied to 0.

Verification
REQ-033 Reset, req_valid=4'b0011, data0=8'h5A, data1=8'h0F, res_ready=1 -> req_ready 0001 then 0010, one-cycle a_en/b_en/y_rdy, res_data=8'h55, res_tag=4'b0001.
REQ-034 All four valid continuously, 3 pairs -> tags 0001, 1011, 0001; rr_ptr wraps 2->0.
REQ-035 Only req_valid[2] high -> A granted from 2, FSM holds GRAB_B; raise req_valid[0] 10 cycles later -> tag 4'b1000.
REQ-036 res_ready=0 for 5 cycles in RESP -> res_data/res_tag/res_valid stable; no req_ready pulses; completes on res_ready=1.
REQ-037 With COIN_SCHED_TIMEOUT_EN, acceptor stubbed y_en=0 -> TIMEOUT_CYC=8 cycles after ISSUE: res_valid=1, res_data=8'hFF, err=1 sticky.
REQ-038 rst_n low during GRAB_B and during WAIT -> all outputs at REQ-029 values same cycle; next pair starts at requester 0.
